// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift sequencer: operation modes, FSM states
// and a helper that classifies which modes step the register.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for modes that move bits one position per step.
  function automatic logic is_shift_mode(mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit step: next register value and the bit that leaves it.
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e            mode,
  input  logic [WIDTH-1:0] y,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] y_next_c,
  output logic             out_bit_c
);

  always_comb begin
    y_next_c  = y;
    out_bit_c = 1'b0;
    case (mode)
      MODE_SHL: begin
        y_next_c  = {y[WIDTH-2:0], sin_l};
        out_bit_c = y[WIDTH-1];
      end
      MODE_SHR: begin
        y_next_c  = {sin_r, y[WIDTH-1:1]};
        out_bit_c = y[0];
      end
      MODE_ROL: begin
        y_next_c  = {y[WIDTH-2:0], y[WIDTH-1]};
        out_bit_c = y[WIDTH-1];
      end
      MODE_ROR: begin
        y_next_c  = {y[0], y[WIDTH-1:1]};
        out_bit_c = y[0];
      end
      MODE_ASR: begin
        y_next_c  = {y[WIDTH-1], y[WIDTH-1:1]};
        out_bit_c = y[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Universal shift register sequencer: load/hold in one cycle, or perform a latched
// number of one-bit shift/rotate steps, then pulse done.
module univ_shift_seq
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Y,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_e            mode_in;
  logic [WIDTH-1:0] step_y;
  logic             step_out;

  assign mode_in = mode_e'(mode);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode      (mode_q),
    .y         (y_q),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .y_next_c  (step_y),
    .out_bit_c (step_out)
  );

  // Next-state, counter and datapath; busy/done are registered from the next state.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    sout_d  = sout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_in == MODE_LOAD) begin
            y_d     = load_data;
            state_d = ST_DONE;
          end else if (is_shift_mode(mode_in) && (amt != '0)) begin
            mode_d  = mode_in;
            cnt_d   = amt;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        y_d    = step_y;
        sout_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      y_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Y    = y_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Scoreboard bench for univ_shift_seq (WIDTH=8): stimulus pushes hand-computed
// expected observations; a negedge monitor pops one whenever busy or done is high.
module tb_univ_shift_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] y;
    logic       sout;
  } ev_t;

  logic             clk = 1'b0;
  logic             r_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       mode = 3'b000;
  logic [CNT_W-1:0] amt = '0;
  logic [WIDTH-1:0] load_data = '0;
  logic             sin_l = 1'b0;
  logic             sin_r = 1'b0;
  logic [WIDTH-1:0] y;
  logic             sout, busy, done;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  univ_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .R         (r_n),
    .start     (start),
    .mode      (mode),
    .amt       (amt),
    .load_data (load_data),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .Y         (y),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic void push_ev(logic b, logic d, logic [7:0] yv, logic s);
    ev_t e;
    e.busy = b; e.done = d; e.y = yv; e.sout = s;
    sb.push_back(e);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every busy/done observation must match the next queued expectation.
  always @(negedge clk) begin
    if (r_n && (busy || done)) begin
      ev_t act, req;
      act.busy = busy; act.done = done; act.y = y; act.sout = sout;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual(b,d,y,s)=%b,%b,%h,%b required=none",
                 busy, done, y, sout);
      end else begin
        req = sb.pop_front();
        if (act !== req) begin
          errors++;
          $display("FAIL event actual(b,d,y,s)=%b,%b,%h,%b required=%b,%b,%h,%b",
                   act.busy, act.done, act.y, act.sout, req.busy, req.done, req.y, req.sout);
        end
      end
    end
  end

  // Called at posedge+1; start is sampled at the following edge (E0).
  task automatic issue(logic [2:0] m, logic [CNT_W-1:0] n, logic [7:0] d);
    start = 1'b1; mode = m; amt = n; load_data = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait until every queued expectation has been observed; leaves the DUT in IDLE.
  task automatic wait_drain(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout_%s actual_pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] rol_seq [0:9];
    logic       rol_out [0:9];
    rol_seq = '{8'h79, 8'hF2, 8'hE5, 8'hCB, 8'h97, 8'h2F, 8'h5E, 8'hBC, 8'h79, 8'hF2};
    rol_out = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    #3;
    chk("reset_y", 16'(y), 16'h00);
    chk("reset_sout", 16'(sout), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_done", 16'(done), 16'h0);
    @(posedge clk); @(posedge clk); #1;
    r_n = 1'b1;

    push_ev(0, 1, 8'hA5, 0);
    issue(M_LOAD, 4'd0, 8'hA5);
    wait_drain("load_a5");

    sin_l = 1'b1;
    push_ev(1, 0, 8'hA5, 0); push_ev(1, 0, 8'h4B, 1);
    push_ev(1, 0, 8'h97, 0); push_ev(0, 1, 8'h2F, 1);
    issue(M_SHL, 4'd3, 8'h00);
    wait_drain("shl3");

    push_ev(0, 1, 8'hA5, 1);
    issue(M_LOAD, 4'd0, 8'hA5);
    wait_drain("load_a5_b");
    push_ev(1, 0, 8'hA5, 1); push_ev(1, 0, 8'hD2, 1); push_ev(1, 0, 8'h69, 0);
    push_ev(1, 0, 8'hB4, 1); push_ev(0, 1, 8'h5A, 0);
    issue(M_ROR, 4'd4, 8'h00);
    wait_drain("ror4");

    push_ev(0, 1, 8'h90, 0);
    issue(M_LOAD, 4'd0, 8'h90);
    wait_drain("load_90");
    push_ev(1, 0, 8'h90, 0); push_ev(1, 0, 8'hC8, 0); push_ev(0, 1, 8'hE4, 0);
    issue(M_ASR, 4'd2, 8'h00);
    wait_drain("asr2");

    push_ev(0, 1, 8'hE4, 0);
    issue(M_SHR, 4'd0, 8'h00);
    wait_drain("shr0");

    // SHR with live sin_r changes and a LOAD request held through SHIFT and DONE.
    sin_r = 1'b1;
    push_ev(1, 0, 8'hE4, 0); push_ev(1, 0, 8'hF2, 0); push_ev(0, 1, 8'h79, 0);
    issue(M_SHR, 4'd2, 8'h00);
    start = 1'b1; mode = M_LOAD; load_data = 8'hFF;
    @(posedge clk); #1; sin_r = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; start = 1'b0;
    wait_drain("shr2_ignore_load");
    chk("no_load_during_shift", 16'(y), 16'h79);

    push_ev(0, 1, 8'h79, 0);
    issue(M_RSVD, 4'd5, 8'h00);
    wait_drain("rsvd");
    push_ev(0, 1, 8'h79, 0);
    issue(M_HOLD, 4'd3, 8'h11);
    wait_drain("hold");

    // Rotate by more than WIDTH wraps around.
    for (int i = 0; i < 10; i++) push_ev(i != 9, i == 9, rol_seq[i], rol_out[i]);
    issue(M_ROL, 4'd9, 8'h00);
    wait_drain("rol9");

    // Reset in the middle of a shift discards it.
    push_ev(0, 1, 8'hA5, 0);
    issue(M_LOAD, 4'd0, 8'hA5);
    wait_drain("load_a5_c");
    push_ev(1, 0, 8'hA5, 0); push_ev(1, 0, 8'h4B, 1);
    issue(M_SHL, 4'd5, 8'h00);
    @(posedge clk);
    @(negedge clk); #2;
    r_n = 1'b0;
    #1;
    chk("midreset_y", 16'(y), 16'h00);
    chk("midreset_sout", 16'(sout), 16'h0);
    chk("midreset_busy", 16'(busy), 16'h0);
    chk("midreset_done", 16'(done), 16'h0);
    chk("midreset_pending", 16'(sb.size()), 16'd0);
    @(posedge clk); @(posedge clk); #1;
    r_n = 1'b1;
    push_ev(0, 1, 8'h3C, 0);
    issue(M_LOAD, 4'd0, 8'h3C);
    chk("first_start_after_reset_y", 16'(y), 16'h3C);
    wait_drain("load_after_reset");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_seq.md
UNIV_SHIFT_SEQ -- requirements
Module: univ_shift_seq

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (SHALL be >= 2).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of shift-amount input and internal step counter.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port R  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port mode  input  3  operation select, sampled with start.
REQ-007 Port amt  input  CNT_W  number of one-bit steps, sampled with start.
REQ-008 Port load_data  input  WIDTH  parallel load value, sampled with start.
REQ-009 Port sin_l  input  1  serial fill bit entering Y[0] on logical left shift.
REQ-010 Port sin_r  input  1  serial fill bit entering Y[WIDTH-1] on logical right shift.
REQ-011 Port Y  output  WIDTH  register contents.
REQ-012 Port sout  output  1  bit most recently shifted or rotated out.
REQ-013 Port busy  output  1  high while in SHIFT.
REQ-014 Port done  output  1  one-cycle completion pulse.

Function
REQ-015 Mode encodings SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR (fill with Y[WIDTH-1]), 111 reserved (behaves as HOLD).
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE; DONE SHALL return to IDLE unconditionally after one cycle.
REQ-017 IDLE, start=1, mode LOAD: Y <= load_data at that edge; next state DONE.
REQ-018 IDLE, start=1, mode HOLD or 111: Y and sout unchanged; next state DONE.
REQ-019 IDLE, start=1, shift/rotate mode, amt=0: Y unchanged; next state DONE.
REQ-020 IDLE, start=1, shift/rotate mode, amt=n>0: mode and n latched; next state SHIFT; Y not modified at this edge.
REQ-021 In SHIFT, each edge SHALL perform exactly one one-bit step of the latched mode and decrement the counter; after the n-th step, next state DONE.
REQ-022 Latency: start sampled at edge E0; steps occur at E1..En; final Y and done visible after En; done low after En+1.
REQ-023 sin_l/sin_r SHALL be sampled live at each step edge, not latched at start.
REQ-024 sout SHALL update at each step to the bit leaving the register (MSB for SHL/ROL, LSB for SHR/ROR/ASR); LOAD and HOLD leave it unchanged.
REQ-025 amt > WIDTH SHALL NOT be clamped; all steps are performed (logical shifts saturate to fill pattern, rotates wrap).
REQ-026 start, mode, amt, load_data SHALL be ignored in SHIFT and DONE; busy=1 only in SHIFT, done=1 only in DONE.

Reset
REQ-027 R=0 SHALL immediately force Y=0, sout=0, busy=0, done=0, counter=0, state IDLE, including mid-SHIFT; operation in progress is discarded.
REQ-028 After R returns to 1, first start SHALL be honoured at the next rising clk edge.

Structure
REQ-029 Mode encodings and FSM state encodings SHALL reside in shared package univ_shift_pkg.
REQ-030 One-bit step logic (mode, Y, sin_l, sin_r -> next Y, out bit) SHALL be a combinational sub-module shift_step; FSM, counter, registers in univ_shift_seq.

Verification (WIDTH=8)
REQ-031 LOAD 0xA5, then SHIFT mid-way with R=0 -> Y=0x00, busy=0, done=0 immediately; no done pulse follows.
REQ-032 LOAD 0xA5; SHL amt=3, sin_l=1 -> Y=0x4B, 0x97, 0x2F on E1..E3; sout=1; done high one cycle after E3; busy high 3 cycles.
REQ-033 LOAD 0xA5; ROR amt=4 -> Y=0xD2, 0x69, 0xB4, 0x5A; final sout=0.
REQ-034 LOAD 0x90; ASR amt=2 -> Y=0xC8, 0xE4.
REQ-035 SHR amt=0 -> done after E0, Y unchanged; start with LOAD 0xFF asserted during SHIFT -> ignored, Y not 0xFF.
REQ-036 mode 111, start=1 -> Y, sout unchanged, done pulses once, busy stays 0.
